rec_slice_fifo: RTL and testbench

- Parametrised record FIFO for packed status records of the form {valid, user[AW-1:0], mask{valid, value}}.
- Buffers records with a valid/ready handshake on both sides.
- Optionally discards masked-off records.
- Presents the full head record plus a selectable SW-bit lane of its user field; the lane is all-ones when the record is invalid.
- Sits between a record producer and downstream consumers that need one byte-lane view of the user field.

---
 rtl/rec_pkg.sv | 30 +++
 rtl/rec_slice_extract.sv | 36 +++
 rtl/rec_slice_fifo.sv | 111 +++++++++++
 tb/tb_rec_slice_fifo.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rec_pkg.sv
// rtl/rec_pkg.sv - record layout types and constants shared by the record FIFO
package rec_pkg;

    localparam int AW = 16;
    localparam int SW = 8;

    typedef struct packed {
        logic valid;
        logic value;
    } mask_t;

    typedef struct packed {
        logic           valid;
        logic [AW-1:0]  user;
        mask_t          mask;
    } rec_t;

    // Flat layout positions; the user field starts at bit 2 for any AW.
    localparam int REC_W          = $bits(rec_t);
    localparam int BIT_VALID      = AW + 2;
    localparam int BIT_USER_LSB   = 2;
    localparam int BIT_MASK_VALID = 1;
    localparam int BIT_MASK_VALUE = 0;

    // Lane select width: enough bits to address AW/SW lanes, never zero.
    function automatic int lane_width(input int aw, input int sw);
        return (aw / sw > 1) ? $clog2(aw / sw) : 1;
    endfunction

endpackage

// File: rtl/rec_slice_extract.sv
// rtl/rec_slice_extract.sv - combinational SW-bit lane view of a record's user field
module rec_slice_extract
    import rec_pkg::*;
#(
    parameter int AW = rec_pkg::AW,
    parameter int SW = rec_pkg::SW,
    parameter int LW = lane_width(AW, SW)
) (
    input  logic [AW+2:0] rec,
    input  logic [LW-1:0] lane,
    input  logic          valid,
    output logic [SW-1:0] slice
);

    localparam int NL = AW / SW;

    // The mask bits play no part in the lane view.
    logic unused_mask;
    assign unused_mask = ^rec[BIT_MASK_VALID:BIT_MASK_VALUE];

    // Zero when nothing is presented; all-ones for invalid records or out-of-range lanes.
    always_comb begin
        slice = '0;
        if (valid) begin
            slice = '1;
            if (rec[AW+2]) begin
                for (int i = 0; i < NL; i++) begin
                    if (lane == LW'(i)) begin
                        slice = rec[BIT_USER_LSB + i*SW +: SW];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rec_slice_fifo.sv
// rtl/rec_slice_fifo.sv - record FIFO with mask filtering and a selectable user-field lane
// Optional synchronous flush port enabled by defining REC_FLUSH_EN.
module rec_slice_fifo
    import rec_pkg::*;
#(
    parameter  int AW          = rec_pkg::AW,
    parameter  int SW          = rec_pkg::SW,
    parameter  int DEPTH       = 4,
    parameter  int MASK_FILTER = 1,
    localparam int LW          = lane_width(AW, SW),
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef REC_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW+2:0] in_data,
    input  logic [LW-1:0] in_lane,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW+2:0] out_rec,
    output logic [SW-1:0] out_slice,
    output logic [CW-1:0] count,
    output logic [7:0]    drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = LW + AW + 3;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [EW-1:0] head;
    logic          push;
    logic          pop;
    logic          drop;
    logic          store;

    // No bypass: a full FIFO refuses input even if the head leaves this cycle.
`ifdef REC_FLUSH_EN
    assign in_ready = (count != CW'(DEPTH)) && !flush;
`else
    assign in_ready = (count != CW'(DEPTH));
`endif

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign drop      = push && (MASK_FILTER != 0) && in_data[BIT_MASK_VALID] && !in_data[BIT_MASK_VALUE];
    assign store     = push && !drop;

    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_rec   = out_valid ? head[AW+2:0] : '0;

    // Pointers, occupancy and the saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
`ifdef REC_FLUSH_EN
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
`endif
                if (store) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (store && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !store) begin
                    count <= count - CW'(1);
                end
                if (drop && drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
`ifdef REC_FLUSH_EN
            end
`endif
        end
    end

    // Record storage keeps its lane select alongside; contents are never reset.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= {in_lane, in_data};
        end
    end

    rec_slice_extract #(
        .AW (AW),
        .SW (SW),
        .LW (LW)
    ) u_extract (
        .rec   (head[AW+2:0]),
        .lane  (head[EW-1 -: LW]),
        .valid (out_valid),
        .slice (out_slice)
    );

endmodule

// File: tb/tb_rec_slice_fifo.sv
// tb/tb_rec_slice_fifo.sv - scoreboard bench for rec_slice_fifo and rec_slice_extract
module tb_rec_slice_fifo;

    localparam int DEPTH = 4;
    localparam logic [18:0] R_A   = {1'b1, 16'h921D, 2'b00};
    localparam logic [18:0] R_INV = {1'b0, 16'h921D, 2'b00};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] in_data;
    logic [0:0]  in_lane;
    logic        out_valid;
    logic        out_ready;
    logic [18:0] out_rec;
    logic [7:0]  out_slice;
    logic [2:0]  count;
    logic [7:0]  drop_cnt;
`ifdef REC_FLUSH_EN
    logic        flush = 1'b0;
`endif

    logic [18:0] x_rec;
    logic [1:0]  x_lane;
    logic        x_valid;
    logic [7:0]  x_slice;

    int vectors = 0;
    int errors  = 0;

    logic [19:0] sq[$];
    int          mdrop = 0;

    always #5 clk = ~clk;

    rec_slice_fifo #(
        .AW          (16),
        .SW          (8),
        .DEPTH       (DEPTH),
        .MASK_FILTER (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef REC_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_lane   (in_lane),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rec   (out_rec),
        .out_slice (out_slice),
        .count     (count),
        .drop_cnt  (drop_cnt)
    );

    rec_slice_extract #(
        .AW (16),
        .SW (8),
        .LW (2)
    ) u_x (
        .rec   (x_rec),
        .lane  (x_lane),
        .valid (x_valid),
        .slice (x_slice)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference lane view: {lane, record} -> byte of user, or all-ones.
    function automatic logic [7:0] exp_slice(input logic [19:0] e);
        logic [15:0] user;
        int          lane;
        user = e[17:2];
        lane = int'(e[19]);
        if (!e[18] || lane >= 2) return 8'hFF;
        return user[lane*8 +: 8];
    endfunction

    // Monitor: compare outputs against the queue model, then advance the model.
    always @(negedge clk) begin : monitor
        bit do_push;
        bit do_pop;
        bit fl;
        if (!rst_n) begin
            sq.delete();
            mdrop = 0;
            chk("rst_count", count, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_rec", out_rec, 0);
            chk("rst_drop_cnt", drop_cnt, 0);
        end else begin
            fl = 1'b0;
`ifdef REC_FLUSH_EN
            fl = flush;
`endif
            chk("count", count, sq.size());
            chk("out_valid", out_valid, sq.size() != 0);
            chk("in_ready", in_ready, (sq.size() != DEPTH) && !fl);
            chk("drop_cnt", drop_cnt, mdrop);
            if (sq.size() != 0) begin
                chk("out_rec", out_rec, sq[0][18:0]);
                chk("out_slice", out_slice, exp_slice(sq[0]));
            end else begin
                chk("out_rec_idle", out_rec, 0);
                chk("out_slice_idle", out_slice, 0);
            end
            do_push = in_valid && (sq.size() < DEPTH) && !fl;
            do_pop  = (sq.size() != 0) && out_ready;
            if (fl) begin
                sq.delete();
            end else begin
                if (do_pop) void'(sq.pop_front());
                if (do_push) begin
                    if (in_data[1] && !in_data[0]) begin
                        if (mdrop < 255) mdrop++;
                    end else begin
                        sq.push_back({in_lane, in_data});
                    end
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [18:0] d, input logic ln, input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_lane   = ln;
        out_ready = ordy;
    endtask

    initial begin
        logic [7:0]  xexp [4];
        logic [18:0] rd;
        xexp = '{8'h1D, 8'h92, 8'hFF, 8'hFF};
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_lane = '0; out_ready = 1'b0;
        x_rec = R_A; x_lane = '0; x_valid = 1'b1;

        // Standalone lane extractor, including lanes beyond AW/SW.
        for (int i = 0; i < 4; i++) begin
            x_lane = 2'(i);
            #1;
            chk("x_lane", x_slice, xexp[i]);
        end
        x_rec = R_INV; x_lane = 2'd0; #1;
        chk("x_invalid_rec", x_slice, 8'hFF);
        x_valid = 1'b0; #1;
        chk("x_not_valid", x_slice, 8'h00);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_rec", out_rec, 0);
        chk("reset_out_slice", out_slice, 0);
        chk("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // Lane 0 and lane 1 views of 0x921D.
        cyc(1, R_A, 0, 0);
        cyc(0, '0, 0, 0);
        chk("t1_valid", out_valid, 1);
        chk("t1_count", count, 1);
        chk("t1_lane0", out_slice, 8'h1D);
        cyc(0, '0, 0, 1);
        cyc(1, R_A, 1, 0);
        cyc(0, '0, 0, 0);
        chk("t1_lane1", out_slice, 8'h92);
        cyc(0, '0, 0, 1);

        // Invalid record reads as all-ones.
        cyc(1, R_INV, 0, 0);
        cyc(0, '0, 0, 0);
        chk("t2_invalid", out_slice, 8'hFF);
        cyc(0, '0, 0, 1);

        // Mask 10 is filtered, mask 11 is stored.
        cyc(1, {1'b1, 16'h1234, 2'b10}, 0, 0);
        cyc(0, '0, 0, 0);
        chk("t3_filtered_count", count, 0);
        chk("t3_drop", drop_cnt, 1);
        cyc(1, {1'b1, 16'h1234, 2'b11}, 1, 0);
        cyc(0, '0, 0, 0);
        chk("t3_kept_count", count, 1);
        chk("t3_kept_slice", out_slice, 8'h12);
        cyc(0, '0, 0, 1);

        // Fill, then push and pop together across pointer wrap.
        for (int i = 0; i < 4; i++) begin
            rd = {1'b1, 16'($urandom), 2'b0};
            cyc(1, rd, 1'($urandom), 0);
        end
        cyc(0, '0, 0, 0);
        chk("t4_full_count", count, 4);
        chk("t4_full_ready", in_ready, 0);
        for (int i = 0; i < 6; i++) begin
            rd = {1'b1, 16'($urandom), 2'b0};
            cyc(1, rd, 1'($urandom), 1);
        end
        repeat (6) cyc(0, '0, 0, 1);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            rd = 19'($urandom);
            cyc(1'($urandom), rd, 1'($urandom), 1'($urandom));
        end
        repeat (6) cyc(0, '0, 0, 1);

        // Drop counter saturates at 255.
        for (int i = 0; i < 260; i++) begin
            rd = {1'($urandom), 16'($urandom), 2'b10};
            cyc(1, rd, 0, 0);
        end
        cyc(0, '0, 0, 0);
        chk("drop_saturate", drop_cnt, 255);

        // Asynchronous reset mid-stream with three records held.
        for (int i = 0; i < 3; i++) begin
            rd = {1'b1, 16'($urandom), 2'b0};
            cyc(1, rd, 0, 0);
        end
        cyc(0, '0, 0, 0);
        chk("t5_count_before", count, 3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_count", count, 0);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_out_rec", out_rec, 0);
        chk("t5_drop_cnt", drop_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef REC_FLUSH_EN
        // Flush with a coincident push empties the FIFO and leaves drop_cnt alone.
        cyc(1, {1'b1, 16'h00AA, 2'b10}, 0, 0);
        cyc(1, R_A, 0, 0);
        cyc(1, R_A, 1, 0);
        cyc(0, '0, 0, 0);
        chk("t6_count_before", count, 2);
        cyc(1, R_A, 0, 1);
        flush = 1'b1;
        cyc(0, '0, 0, 0);
        flush = 1'b0;
        chk("t6_count", count, 0);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_drop_cnt", drop_cnt, 1);
`endif

        repeat (2) cyc(0, '0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
